// File: rtl/datapath_stack_pkg.sv
// Shared types for the accumulator datapath: ALU function codes and PC control.
package datapath_stack_pkg;

    typedef enum logic [2:0] {
        AluAdd   = 3'd0,
        AluSub   = 3'd1,
        AluAnd   = 3'd2,
        AluOr    = 3'd3,
        AluXor   = 3'd4,
        AluPassA = 3'd5,
        AluPassB = 3'd6,
        AluNotA  = 3'd7
    } alu_functions_t;

    // 3'd7 is left unassigned and decodes as a hold.
    typedef enum logic [2:0] {
        PcHold = 3'd0,
        PcInc  = 3'd1,
        PcJmp  = 3'd2,
        PcBrz  = 3'd3,
        PcBrn  = 3'd4,
        PcCall = 3'd5,
        PcRet  = 3'd6
    } pc_ctl_t;

endpackage

// File: rtl/datapath_stack_ret_stack.sv
// Return-address LIFO; push when full and pop when empty are silently dropped.
module datapath_stack_ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Push,
    input  logic         Pop,
    input  logic [W-1:0] DIn,
    output logic [W-1:0] DOut,
    output logic         Empty,
    output logic         Full
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ptr counts live entries 0..DEPTH, so full/empty never rely on wrap.
    logic [PW-1:0]         ptr;
    logic [DEPTH-1:0][W-1:0] mem;

    assign Empty = (ptr == '0);
    assign Full  = (ptr == PW'(DEPTH));
    assign DOut  = mem[AW'(ptr - PW'(1))];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr <= '0;
            mem <= '0;
        end else if (Push && !Full) begin
            mem[AW'(ptr)] <= DIn;
            ptr           <= ptr + PW'(1);
        end else if (Pop && !Empty) begin
            ptr <= ptr - PW'(1);
        end
    end

endmodule

// File: rtl/datapath_stack.sv
// Accumulator datapath: operand muxes, ALU, Acc with Zero/Neg flags, register
// file, PC sequencing with conditional branches and a call/return stack.
module datapath_stack
    import datapath_stack_pkg::*;
#(
    parameter int N          = 8,
    parameter int REGCOUNT   = 10,
    parameter int IMMW       = 4,
    parameter int STACKDEPTH = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Stall,
    input  logic [N-1:0]   MemData,
    input  logic [N-1:0]   Switches,
    input  logic           RegWe,
    input  logic           ImmSel,
    input  logic           WDataSel,
    input  logic           AccStore,
    input  logic           Op1Sel,
    input  logic           Op2Sel,
    input  alu_functions_t AluOp,
    input  pc_ctl_t        PcSel,
    output logic [N-1:0]   MemAddr,
    output logic [N-1:0]   LEDs,
    output logic           ZeroFlag,
    output logic           NegFlag,
    output logic           StackEmpty,
    output logic           StackFull,
    output logic           StackErr
);
    logic [N-1:0]                pc, acc, acc_in, pc_next, pc_inc;
    logic [N-1:0]                imm, reg_data, op_a, op_b, stack_top;
    logic [IMMW-1:0]             reg_addr;
    logic [REGCOUNT-1:0][N-1:0]  regs;
    logic                        zero_q, neg_q, err_q;
    logic                        push_req, pop_req, err_set;
    logic                        unused_mem;

    assign unused_mem = ^MemData;
    assign reg_addr   = MemData[IMMW-1:0];
    // Shift form also covers IMMW == N, where there are no pad bits.
    assign imm        = ImmSel ? (N'(reg_addr) << (N - IMMW)) : N'(reg_addr);

    // Addresses at or beyond REGCOUNT read as zero.
    always_comb begin
        reg_data = '0;
        for (int i = 0; i < REGCOUNT; i++)
            if (reg_addr == IMMW'(i)) reg_data = regs[i];
    end

    assign op_a = Op1Sel ? imm : reg_data;
    assign op_b = Op2Sel ? pc  : acc;

    always_comb begin
        acc_in = '0;
        case (AluOp)
            AluAdd:   acc_in = op_a + op_b;
            AluSub:   acc_in = op_a - op_b;
            AluAnd:   acc_in = op_a & op_b;
            AluOr:    acc_in = op_a | op_b;
            AluXor:   acc_in = op_a ^ op_b;
            AluPassA: acc_in = op_a;
            AluPassB: acc_in = op_b;
            AluNotA:  acc_in = ~op_a;
            default:  acc_in = '0;
        endcase
    end

    assign pc_inc = pc + N'(1);

    // Branches look at the flags as registered before this edge.
    always_comb begin
        pc_next  = pc;
        push_req = 1'b0;
        pop_req  = 1'b0;
        err_set  = 1'b0;
        case (PcSel)
            PcHold: pc_next = pc;
            PcInc:  pc_next = pc_inc;
            PcJmp:  pc_next = acc_in;
            PcBrz:  pc_next = zero_q ? acc_in : pc_inc;
            PcBrn:  pc_next = neg_q  ? acc_in : pc_inc;
            PcCall: begin
                push_req = !StackFull;
                err_set  = StackFull;
                pc_next  = StackFull ? pc_inc : acc_in;
            end
            PcRet: begin
                pop_req = !StackEmpty;
                err_set = StackEmpty;
                pc_next = StackEmpty ? pc_inc : stack_top;
            end
            default: pc_next = pc;
        endcase
    end

    datapath_stack_ret_stack #(.W(N), .DEPTH(STACKDEPTH)) u_ret_stack (
        .Clock (Clock),
        .Reset (Reset),
        .Push  (push_req && !Stall),
        .Pop   (pop_req && !Stall),
        .DIn   (pc_inc),
        .DOut  (stack_top),
        .Empty (StackEmpty),
        .Full  (StackFull)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc     <= '0;
            acc    <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            err_q  <= 1'b0;
            regs   <= '0;
        end else if (!Stall) begin
            pc <= pc_next;
            if (err_set) err_q <= 1'b1;
            if (AccStore) begin
                acc    <= acc_in;
                zero_q <= (acc_in == '0);
                neg_q  <= acc_in[N-1];
            end
            if (RegWe)
                for (int i = 0; i < REGCOUNT; i++)
                    if (reg_addr == IMMW'(i)) regs[i] <= WDataSel ? Switches : acc;
        end
    end

    assign MemAddr  = pc;
    assign LEDs     = acc;
    assign ZeroFlag = zero_q;
    assign NegFlag  = neg_q;
    assign StackErr = err_q;

endmodule

// File: tb/tb_datapath_stack.sv
// Randomized and directed bench for datapath_stack against a behavioural model.
module tb_datapath_stack;
    import datapath_stack_pkg::*;

    localparam int N          = 8;
    localparam int REGCOUNT   = 10;
    localparam int IMMW       = 4;
    localparam int STACKDEPTH = 4;

    logic           Clock = 1'b0;
    logic           Reset, Stall, RegWe, ImmSel, WDataSel, AccStore, Op1Sel, Op2Sel;
    logic [N-1:0]   MemData, Switches;
    alu_functions_t AluOp;
    pc_ctl_t        PcSel;
    logic [N-1:0]   MemAddr, LEDs;
    logic           ZeroFlag, NegFlag, StackEmpty, StackFull, StackErr;

    datapath_stack #(.N(N), .REGCOUNT(REGCOUNT), .IMMW(IMMW), .STACKDEPTH(STACKDEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .Stall(Stall), .MemData(MemData), .Switches(Switches),
        .RegWe(RegWe), .ImmSel(ImmSel), .WDataSel(WDataSel), .AccStore(AccStore),
        .Op1Sel(Op1Sel), .Op2Sel(Op2Sel), .AluOp(AluOp), .PcSel(PcSel),
        .MemAddr(MemAddr), .LEDs(LEDs), .ZeroFlag(ZeroFlag), .NegFlag(NegFlag),
        .StackEmpty(StackEmpty), .StackFull(StackFull), .StackErr(StackErr)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [N-1:0] m_pc, m_acc;
    logic         m_zf, m_nf, m_err;
    logic [N-1:0] m_regs [REGCOUNT];
    logic [N-1:0] m_stk [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge, update the model from the pre-edge inputs, compare.
    task automatic step();
        logic [N-1:0] imm, rd, a, b, ai;
        int f;
        f   = int'(MemData[IMMW-1:0]);
        imm = ImmSel ? N'(f * (1 << (N - IMMW))) : N'(f);
        rd  = (f < REGCOUNT) ? m_regs[f] : '0;
        a   = Op1Sel ? imm : rd;
        b   = Op2Sel ? m_pc : m_acc;
        case (AluOp)
            AluAdd:   ai = a + b;
            AluSub:   ai = a - b;
            AluAnd:   ai = a & b;
            AluOr:    ai = a | b;
            AluXor:   ai = a ^ b;
            AluPassA: ai = a;
            AluPassB: ai = b;
            default:  ai = ~a;
        endcase
        @(posedge Clock);
        if (Reset) begin
            m_pc = '0; m_acc = '0; m_zf = 0; m_nf = 0; m_err = 0;
            foreach (m_regs[i]) m_regs[i] = '0;
            m_stk.delete();
        end else if (!Stall) begin
            logic [N-1:0] old_acc;
            old_acc = m_acc;
            case (PcSel)
                PcInc: m_pc = m_pc + 1'b1;
                PcJmp: m_pc = ai;
                PcBrz: m_pc = m_zf ? ai : N'(m_pc + 1'b1);
                PcBrn: m_pc = m_nf ? ai : N'(m_pc + 1'b1);
                PcCall:
                    if (m_stk.size() < STACKDEPTH) begin
                        m_stk.push_back(N'(m_pc + 1'b1));
                        m_pc = ai;
                    end else begin
                        m_pc = m_pc + 1'b1; m_err = 1;
                    end
                PcRet:
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_pc = m_pc + 1'b1; m_err = 1; end
                default: ;
            endcase
            if (RegWe && f < REGCOUNT) m_regs[f] = WDataSel ? Switches : old_acc;
            if (AccStore) begin
                m_acc = ai; m_zf = (ai == 0); m_nf = ai[N-1];
            end
        end
        #1;
        chk("pc",    MemAddr,    m_pc);
        chk("leds",  LEDs,       m_acc);
        chk("zero",  ZeroFlag,   m_zf);
        chk("neg",   NegFlag,    m_nf);
        chk("empty", StackEmpty, m_stk.size() == 0);
        chk("full",  StackFull,  m_stk.size() == STACKDEPTH);
        chk("err",   StackErr,   m_err);
    endtask

    task automatic idle();
        Reset = 0; Stall = 0; RegWe = 0; ImmSel = 0; WDataSel = 0; AccStore = 0;
        Op1Sel = 0; Op2Sel = 0; AluOp = AluPassA; PcSel = PcHold;
        MemData = '0; Switches = '0;
    endtask

    task automatic write_reg(input int addr, input logic [N-1:0] v);
        idle(); RegWe = 1; WDataSel = 1; Switches = v; MemData = N'(addr); step();
    endtask

    task automatic load_acc(input int addr);
        idle(); AccStore = 1; MemData = N'(addr); step();
    endtask

    task automatic pc_op(input pc_ctl_t sel, input int addr);
        idle(); PcSel = sel; MemData = N'(addr); step();
    endtask

    logic [N-1:0] ret_exp [4] = '{8'h41, 8'h41, 8'h41, 8'h11};
    logic [N-1:0] p0, a0;

    initial begin
        m_pc = '0; m_acc = '0; m_zf = 0; m_nf = 0; m_err = 0;
        foreach (m_regs[i]) m_regs[i] = '0;
        idle(); Reset = 1; step(); step();
        chk("rst_pc", MemAddr, 0);
        chk("rst_empty", StackEmpty, 1);

        // Dirty the state, then reset while stalled
        write_reg(1, 8'h50); pc_op(PcCall, 1); pc_op(PcRet, 0); pc_op(PcRet, 0);
        write_reg(1, 8'h37); pc_op(PcJmp, 1);
        write_reg(2, 8'h5A); load_acc(2);
        chk("pre_rst_pc", MemAddr, 8'h37);
        chk("pre_rst_acc", LEDs, 8'h5A);
        idle(); Reset = 1; Stall = 1; step();
        chk("mid_rst_pc", MemAddr, 0);
        chk("mid_rst_leds", LEDs, 0);
        chk("mid_rst_empty", StackEmpty, 1);
        chk("mid_rst_err", StackErr, 0);

        // PC wrap and hold
        write_reg(1, 8'hFF); pc_op(PcJmp, 1);
        pc_op(PcInc, 0);
        chk("pc_wrap", MemAddr, 8'h00);
        repeat (3) pc_op(PcHold, 0);
        chk("pc_hold", MemAddr, 8'h00);

        // Conditional branch on zero
        write_reg(0, 8'h00); load_acc(0);
        write_reg(1, 8'h20); pc_op(PcBrz, 1);
        chk("brz_taken", MemAddr, 8'h20);
        write_reg(2, 8'h05); load_acc(2);
        write_reg(1, 8'h10); pc_op(PcJmp, 1); pc_op(PcBrz, 1);
        chk("brz_not_taken", MemAddr, 8'h11);
        load_acc(0); write_reg(3, 8'h33);
        idle(); AccStore = 1; PcSel = PcBrz; MemData = 8'd3; step();
        chk("brz_old_flag", MemAddr, 8'h33);
        chk("brz_new_zf", ZeroFlag, 0);

        // Stack overflow and underflow
        write_reg(1, 8'h10); pc_op(PcJmp, 1); write_reg(1, 8'h40);
        repeat (4) pc_op(PcCall, 1);
        chk("call4_err", StackErr, 0);
        pc_op(PcCall, 1);
        chk("call5_pc", MemAddr, 8'h41);
        chk("call5_full", StackFull, 1);
        chk("call5_err", StackErr, 1);
        for (int i = 0; i < 4; i++) begin
            pc_op(PcRet, 0);
            chk($sformatf("ret%0d", i), MemAddr, ret_exp[i]);
        end
        pc_op(PcRet, 0);
        chk("ret_empty_pc", MemAddr, 8'h12);
        chk("ret_empty_err", StackErr, 1);

        // Stall freezes everything; release lets it through
        write_reg(5, 8'h66);
        p0 = m_pc; a0 = m_acc;
        idle(); Stall = 1; RegWe = 1; WDataSel = 1; Switches = 8'h99; MemData = 8'd5;
        AccStore = 1; PcSel = PcCall; step();
        chk("stall_pc", MemAddr, p0);
        chk("stall_acc", LEDs, a0);
        chk("stall_empty", StackEmpty, 1);
        Stall = 0; step();
        chk("unstall_pc", MemAddr, 8'h66);
        chk("unstall_acc", LEDs, 8'h66);
        chk("unstall_push", StackEmpty, 0);
        load_acc(5);
        chk("unstall_reg", LEDs, 8'h99);

        // Register file bounds and immediate forms
        write_reg(9, 8'hC3); load_acc(9);
        chk("r9", LEDs, 8'hC3);
        write_reg(12, 8'h55); load_acc(12);
        chk("r12", LEDs, 8'h00);
        idle(); ImmSel = 1; Op1Sel = 1; AccStore = 1; MemData = 8'h0A; step();
        chk("imm_hi", LEDs, 8'hA0);
        chk("imm_neg", NegFlag, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            Reset    = ($urandom_range(0, 59) == 0);
            Stall    = ($urandom_range(0, 4) == 0);
            RegWe    = 1'($urandom);
            ImmSel   = 1'($urandom);
            WDataSel = 1'($urandom);
            AccStore = 1'($urandom);
            Op1Sel   = 1'($urandom);
            Op2Sel   = 1'($urandom);
            AluOp    = alu_functions_t'($urandom_range(0, 7));
            PcSel    = pc_ctl_t'($urandom_range(0, 7));
            MemData  = N'($urandom);
            Switches = N'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
